// File: rtl/uart_pkg.sv
// Shared types and constants for the UART blocks.
// The PARITY state only has behaviour when UART_TX_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic UART_IDLE_LEVEL = 1'b1;
    localparam int   UART_DATA_BITS  = 8;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered write, fall-through read data and occupancy level.
// Push is ignored when full, pop is ignored when empty.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      level_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage carries no reset; the pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;

endmodule

// File: rtl/uart_tx_stream.sv
// 8N1 UART transmitter fed by a byte FIFO over a valid/ready handshake.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx_stream
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = 104,
    parameter int FIFO_DEPTH = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          ser_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output uart_state_e                   state_dbg
);

    localparam logic [15:0] BAUD_RELOAD = 16'(BAUD_DIV - 1);
    localparam logic [2:0]  LAST_BIT    = 3'(UART_DATA_BITS - 1);
    localparam logic        LAST_STOP   = 1'(STOP_BITS - 1);

    // Handshake: a byte transfers on a rising edge where tx_valid && tx_ready;
    // tx_ready is !full and depends only on registered state.
    uart_state_e state_q, state_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        stop_idx_q, stop_idx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        ser_bit;
    logic        ser_tx_q;
    logic        bit_end;
    logic        load;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_rd_data;
`ifdef UART_TX_PARITY_EN
    logic        par_q, par_d;
`endif

    uart_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (tx_valid),
        .wr_data (tx_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign bit_end = (baud_cnt_q == '0);

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        shreg_d    = shreg_q;
        ser_bit    = UART_IDLE_LEVEL;
        load       = 1'b0;
        fifo_pop   = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d      = par_q;
`endif

        if (state_q != IDLE) begin
            baud_cnt_d = bit_end ? BAUD_RELOAD : baud_cnt_q - 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    load = 1'b1;
                end
            end
            START: begin
                ser_bit = 1'b0;
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                ser_bit = shreg_q[0];
                if (bit_end) begin
                    shreg_d   = shreg_q >> 1;
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == LAST_BIT) begin
                        stop_idx_d = 1'b0;
`ifdef UART_TX_PARITY_EN
                        state_d    = PARITY;
`else
                        state_d    = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                ser_bit = par_q;
                if (bit_end) begin
                    state_d    = STOP;
                    stop_idx_d = 1'b0;
                end
            end
`endif
            STOP: begin
                ser_bit = UART_IDLE_LEVEL;
                if (bit_end) begin
                    if (stop_idx_q != LAST_STOP) begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end else if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Popping straight from STOP into START keeps frames back-to-back.
        if (load) begin
            fifo_pop   = 1'b1;
            shreg_d    = fifo_rd_data;
            baud_cnt_d = BAUD_RELOAD;
            state_d    = START;
`ifdef UART_TX_PARITY_EN
            par_d      = ^fifo_rd_data;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            shreg_q    <= '0;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            shreg_q    <= shreg_d;
`ifdef UART_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    // Line level is registered from the current state, so it lags the state by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ser_tx_q <= UART_IDLE_LEVEL;
        end else begin
            ser_tx_q <= ser_bit;
        end
    end

    assign ser_tx    = ser_tx_q;
    assign tx_ready  = !fifo_full;
    assign busy      = (state_q != IDLE) || (fifo_level != '0);
    assign state_dbg = state_q;

endmodule
